// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the extended synchronous FIFO.
//   ptr_width(depth) : width of a wrap-bit pointer (address bits + 1)
//   fifo_mode_e      : read-side behaviour selected by the FWFT parameter
package sync_fifo_pkg;

  typedef enum logic {
    MODE_REG  = 1'b0,
    MODE_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage for the extended FIFO: one synchronous write port and one
// asynchronous read port. Contents are never reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with fill level, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and a selectable FWFT read mode.
//   clk, rst_n       : clock, asynchronous active-low reset
//   wr_en, w_data    : push request and data
//   rd_en            : pop request
//   r_data, r_valid  : read data and its qualifier
//   full, empty      : count == FIFO_DEPTH / count == 0
//   almost_full      : count >= AFULL_THRESH
//   almost_empty     : count <= AEMPTY_THRESH
//   count            : stored entries
//   overflow         : sticky, write attempted while full
//   underflow        : sticky, read attempted while empty
//   clr_err          : synchronous clear of overflow/underflow
module sync_fifo_ext
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [DATA_WIDTH-1:0]             w_data,
  input  logic                              rd_en,
  output logic [DATA_WIDTH-1:0]             r_data,
  output logic                              r_valid,
  output logic                              full,
  output logic                              empty,
  output logic                              almost_full,
  output logic                              almost_empty,
  output logic [ptr_width(FIFO_DEPTH)-1:0]  count,
  output logic                              overflow,
  output logic                              underflow,
  input  logic                              clr_err
);

  localparam int              PW       = ptr_width(FIFO_DEPTH);
  localparam int              AW       = PW - 1;
  localparam fifo_mode_e      MODE     = (FWFT != 0) ? MODE_FWFT : MODE_REG;
  localparam logic [PW-1:0]   DEPTH_C  = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0]   AFULL_C  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0]   AEMPTY_C = PW'(AEMPTY_THRESH);
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sync_fifo_ext: FIFO_DEPTH must be a power of two and >= 2");
  end
  if ((AFULL_THRESH < 1) || (AFULL_THRESH > FIFO_DEPTH)) begin : g_bad_afull
    $error("sync_fifo_ext: AFULL_THRESH out of range 1..FIFO_DEPTH");
  end
  if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > FIFO_DEPTH - 1)) begin : g_bad_aempty
    $error("sync_fifo_ext: AEMPTY_THRESH out of range 0..FIFO_DEPTH-1");
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Status is decoded purely from the registered pointers; the wrap bit
  // makes the modular difference distinguish full from empty.
  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_d    = wr_acc ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d    = rd_acc ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    // A new error in the same cycle as clr_err must survive the clear.
    overflow_d  = (wr_en & full)  ? 1'b1 : (clr_err ? 1'b0 : overflow_q);
    underflow_d = (rd_en & empty) ? 1'b1 : (clr_err ? 1'b0 : underflow_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (w_data),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  if (MODE == MODE_REG) begin : g_reg_read
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                  r_valid_q;

    always_comb begin
      r_data_d = rd_acc ? ram_rdata : r_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else begin
        r_data_q  <= r_data_d;
        r_valid_q <= rd_acc;
      end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
  end else begin : g_fwft_read
    // Storage is not reset, so the head word is masked while empty to keep
    // r_data at zero after reset.
    assign r_data  = empty ? '0 : ram_rdata;
    assign r_valid = ~empty;
  end

endmodule

// File: tb/tb_sync_fifo_ext.sv
module tb_sync_fifo_ext;

  localparam int DW = 8;
  localparam int D  = 8;
  localparam int CW = 4;
  localparam int AF = 6;
  localparam int AE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // registered-read instance
  logic          rst_n, wr_en, rd_en, clr_err;
  logic [DW-1:0] w_data, r_data;
  logic          r_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0] count;

  // FWFT instance
  logic          rst_n_f, wr_en_f, rd_en_f, clr_err_f;
  logic [DW-1:0] w_data_f, r_data_f;
  logic          r_valid_f, full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;
  logic [CW-1:0] count_f;

  sync_fifo_ext #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .AFULL_THRESH(AF),
                  .AEMPTY_THRESH(AE), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .w_data(w_data), .rd_en(rd_en),
    .r_data(r_data), .r_valid(r_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err));

  sync_fifo_ext #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .AFULL_THRESH(AF),
                  .AEMPTY_THRESH(AE), .FWFT(1)) dut_f (
    .clk(clk), .rst_n(rst_n_f), .wr_en(wr_en_f), .w_data(w_data_f), .rd_en(rd_en_f),
    .r_data(r_data_f), .r_valid(r_valid_f), .full(full_f), .empty(empty_f),
    .almost_full(almost_full_f), .almost_empty(almost_empty_f), .count(count_f),
    .overflow(overflow_f), .underflow(underflow_f), .clr_err(clr_err_f));

  int total = 0;
  int bad   = 0;

  // reference model: contents as queues, errors as plain bits
  int mq[$];
  int exp_q[$];
  int fq[$];
  bit m_ov, m_uv;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_flags();
    int n;
    n = mq.size();
    chk("count",        int'(count),        n);
    chk("full",         int'(full),         int'(n == D));
    chk("empty",        int'(empty),        int'(n == 0));
    chk("almost_full",  int'(almost_full),  int'(n >= AF));
    chk("almost_empty", int'(almost_empty), int'(n <= AE));
    chk("overflow",     int'(overflow),     int'(m_ov));
    chk("underflow",    int'(underflow),    int'(m_uv));
  endtask

  // One clock of stimulus on the registered-read FIFO.
  task automatic step(input bit wr, input logic [DW-1:0] wd, input bit rd, input bit clr);
    bit was_full, was_empty;
    @(negedge clk);
    wr_en = wr; w_data = wd; rd_en = rd; clr_err = clr;
    was_full  = (mq.size() == D);
    was_empty = (mq.size() == 0);
    if (rd && !was_empty) exp_q.push_back(mq.pop_front());
    if (wr && !was_full)  mq.push_back(int'(wd));
    if (wr && was_full) m_ov = 1'b1; else if (clr) m_ov = 1'b0;
    if (rd && was_empty) m_uv = 1'b1; else if (clr) m_uv = 1'b0;
    @(posedge clk);
    #1;
    check_flags();
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
  endtask

  // Scoreboard monitor: every r_valid pulse must match the oldest accepted read.
  always @(posedge clk) begin
    #2;
    if (rst_n && r_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL r_valid_spurious: got r_valid=1 with data 0x%0h, expected no read at %0t", r_data, $time);
      end else begin
        chk("r_data", int'(r_data), exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus on the FWFT FIFO; the head word is checked directly.
  task automatic step_f(input bit wr, input logic [DW-1:0] wd, input bit rd);
    bit was_full, was_empty;
    @(negedge clk);
    wr_en_f = wr; w_data_f = wd; rd_en_f = rd;
    was_full  = (fq.size() == D);
    was_empty = (fq.size() == 0);
    if (rd && !was_empty) void'(fq.pop_front());
    if (wr && !was_full)  fq.push_back(int'(wd));
    @(posedge clk);
    #1;
    chk("f_count",   int'(count_f),   fq.size());
    chk("f_r_valid", int'(r_valid_f), int'(fq.size() != 0));
    if (fq.size() != 0) chk("f_r_data", int'(r_data_f), fq[0]);
    wr_en_f = 1'b0; rd_en_f = 1'b0;
  endtask

  task automatic check_reset_f();
    chk("f_rst_count",  int'(count_f),        0);
    chk("f_rst_empty",  int'(empty_f),        1);
    chk("f_rst_aempty", int'(almost_empty_f), 1);
    chk("f_rst_full",   int'(full_f),         0);
    chk("f_rst_afull",  int'(almost_full_f),  0);
    chk("f_rst_r_data", int'(r_data_f),       0);
    chk("f_rst_r_valid",int'(r_valid_f),      0);
    chk("f_rst_ovf",    int'(overflow_f),     0);
    chk("f_rst_udf",    int'(underflow_f),    0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; w_data = '0;
    rst_n_f = 1'b0; wr_en_f = 1'b0; rd_en_f = 1'b0; clr_err_f = 1'b0; w_data_f = '0;
    m_ov = 1'b0; m_uv = 1'b0;
    #1;
    check_flags();
    chk("rst_r_data",  int'(r_data),  0);
    chk("rst_r_valid", int'(r_valid), 0);
    check_reset_f();
    @(negedge clk);
    rst_n = 1'b1; rst_n_f = 1'b1;

    // read from empty sets underflow; clr_err clears it
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // fill through both thresholds, then one write too many
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b1, 8'h18, 1'b0, 1'b0);

    // drain in order, then one read too many
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // wrap-around: pointers cross the end of storage
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    chk("ptr_msb_differ", int'(dut.wr_ptr_q[CW-1] ^ dut.rd_ptr_q[CW-1]), 1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // simultaneous read/write: mid-level, full, empty
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);

    // randomized traffic, biased so the FIFO visits both ends
    for (int i = 0; i < 400; i++) begin
      bit wr, rd, clr;
      wr  = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 70 : 30));
      rd  = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 30 : 70));
      clr = ($urandom_range(0, 7) == 0);
      step(wr, 8'($urandom), rd, clr);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("scoreboard_drained", exp_q.size(), 0);

    // FWFT: head word appears one clock after the write, before any rd_en
    step_f(1'b1, 8'hA1, 1'b0);
    chk("f_first_word", int'(r_data_f), 8'hA1);
    for (int i = 0; i < 4; i++) step_f(1'b1, 8'(8'hA2 + i), 1'b0);
    step_f(1'b0, 8'h00, 1'b1);
    step_f(1'b1, 8'hB0, 1'b1);
    for (int i = 0; i < 30; i++)
      step_f(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));

    // reset mid-burst, between clock edges, while a write is still requested
    step_f(1'b1, 8'hC0, 1'b0);
    @(posedge clk);
    #3;
    wr_en_f = 1'b1; w_data_f = 8'hC1;
    rst_n_f = 1'b0;
    #1;
    fq.delete();
    check_reset_f();
    @(posedge clk);
    #1;
    check_reset_f();
    @(negedge clk);
    wr_en_f = 1'b0;
    rst_n_f = 1'b1;
    step_f(1'b1, 8'hD5, 1'b0);
    step_f(1'b0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
- Parametrised next-generation single-clock FIFO that generalises the existing wrap-around-pointer FIFO.
- Adds a fill-level output, programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between single-clock producer/consumer stages wherever the plain FIFO is used today.
- The port names of the plain FIFO are kept, so existing benches port over directly.

Parameters:
- DATA_WIDTH, 8: width of each stored word.
- FIFO_DEPTH, 8: number of entries; must be a power of two and at least 2.
- AFULL_THRESH, 6: almost_full asserts when count >= AFULL_THRESH; legal range 1..FIFO_DEPTH.
- AEMPTY_THRESH, 2: almost_empty asserts when count <= AEMPTY_THRESH; legal range 0..FIFO_DEPTH-1.
- FWFT, 0: 0 = registered-read mode; 1 = first-word-fall-through mode.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- w_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (pop).
- r_data  out  DATA_WIDTH  read data.
- r_valid  out  1  r_data holds valid read data.
- full  out  1  count == FIFO_DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  $clog2(FIFO_DEPTH)+1  current number of stored entries.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (asynchronous, rst_n low), applies immediately, also mid-operation:
  - wr_ptr, rd_ptr and count = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - r_data = 0, r_valid = 0, overflow = 0, underflow = 0.
  - Storage array is not reset; its contents are don't-care after reset.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(FIFO_DEPTH)+1 bits wide; the MSB is the wrap bit.
  - The low bits index storage and roll over from FIFO_DEPTH-1 to 0 with no gap.
  - count = wr_ptr - rd_ptr, modulo 2^(ptr width).
- Flags: full, empty, almost_full, almost_empty and count are all decoded from registered pointers, so they change the cycle after the edge that moves a pointer.
- Accept rules:
  - Write is accepted when wr_en && !full.
  - Read is accepted when rd_en && !empty.
  - Acceptance is judged against the pre-edge state only; there is no same-cycle pass-through.
- Simultaneous read and write:
  - Not full and not empty: both are accepted and count is unchanged.
  - Full: the read is accepted, the write is rejected and overflow is set.
  - Empty: the write is accepted, the read is rejected and underflow is set.
- Rejected operations leave pointers and storage unchanged.
- Error flags:
  - overflow is set on any rejected write; underflow is set on any rejected read.
  - Both hold until clr_err is high at a clock edge.
  - If a set and clr_err occur in the same cycle, the set wins.
- FWFT = 0 (registered read):
  - On an accepted read, r_data <= mem[rd_ptr] and r_valid = 1 for exactly the next cycle.
  - Otherwise r_valid = 0 and r_data holds its last value.
  - Latency from rd_en to data is 1 clock.
- FWFT = 1 (first-word-fall-through):
  - r_data = mem[rd_ptr] combinationally, and r_valid = !empty.
  - rd_en acknowledges (pops) the word currently presented.
  - A word written into an empty FIFO appears on r_data one clock after the write edge.
- Elaboration-time assertions, which must fail the build when violated:
  - FIFO_DEPTH is a power of two and >= 2.
  - AFULL_THRESH and AEMPTY_THRESH are within their legal ranges.

Decomposition:
- Package sync_fifo_pkg:
  - function ptr_width(depth), returning $clog2(depth)+1.
  - enum fifo_mode_e {MODE_REG, MODE_FWFT}, which the FWFT parameter maps onto.
- Sub-module fifo_ram:
  - Simple dual-port array: 1 write port plus 1 asynchronous read port, DATA_WIDTH x FIFO_DEPTH.
  - The top level owns pointers, flags and the output register.

Test Plan:
1. After reset, assert rd_en for 1 cycle -> underflow = 1, empty stays 1, r_valid stays 0, count = 0; then pulse clr_err -> underflow = 0.
2. Write 0x10..0x17 on consecutive cycles (DEPTH 8, thresholds 6/2):
   - almost_empty falls once count = 3.
   - almost_full rises at count = 6.
   - full rises at count = 8.
   - A 9th write of 0x18 sets overflow, and count stays 8.
3. From the full state, read 8 times (FWFT = 0) -> r_data = 0x10..0x17, each with a 1-cycle r_valid pulse one clock after rd_en; empty = 1 afterwards. A 9th read sets underflow.
4. Wrap-around: write 5, read 5, then write 8 (0x20..0x27) and read 8 -> the data comes back in order and count reaches 8 with the pointer MSBs differing.
5. Simultaneous read and write:
   - With count = 3: count stays 3 and data order is preserved.
   - When full: the read is accepted, count goes to 7, overflow = 1.
   - When empty: the write is accepted, count goes to 1, underflow = 1.
6. FWFT = 1 with an assertion of rst_n mid-traffic:
   - Write 0xA1 -> r_data = 0xA1 and r_valid = 1 one clock later, before any rd_en.
   - Assert rst_n low mid-burst -> all outputs return to their reset values immediately, without waiting for a clock edge.
